// File: rtl/clk_div_ctrl.sv
// Programmable power-of-two clock divider with glitch-free ratio switching at counter wrap.
// Optional macro CLK_DIV_CTRL_TICK_EN enables the tick pulse; otherwise tick is tied low.
module clk_div_ctrl #(
    parameter logic [2:0] DEFAULT_SEL = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] div_sel,
    input  logic       sel_valid,
    output logic       sel_ready,
    output logic       busy,
    output logic       clk_out,
    output logic       tick
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [2:0] act_sel_q, act_sel_d;
    logic [2:0] pend_sel_q, pend_sel_d;
    logic       clk_out_q, clk_out_d;
    logic       wrap;

    // A ratio change is only committed when the counter returns to zero, where every
    // divided output is low, so switching never produces a shortened pulse.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_sel_d  = act_sel_q;
        pend_sel_d = pend_sel_q;
        clk_out_d  = clk_out_q;
        wrap       = en && (cnt_q == 7'd127);

        if (en) begin
            cnt_d = cnt_q + 7'd1;
        end

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d    = PEND;
                    pend_sel_d = div_sel;
                end
            end
            PEND: begin
                if (wrap) begin
                    state_d   = IDLE;
                    act_sel_d = pend_sel_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (act_sel_q == 3'd0) begin
            clk_out_d = 1'b0;
        end else begin
            clk_out_d = cnt_d[act_sel_q - 3'd1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 7'd0;
            act_sel_q  <= DEFAULT_SEL;
            pend_sel_q <= DEFAULT_SEL;
            clk_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_sel_q  <= act_sel_d;
            pend_sel_q <= pend_sel_d;
            clk_out_q  <= clk_out_d;
        end
    end

`ifdef CLK_DIV_CTRL_TICK_EN
    logic tick_q;

    // Registered alongside clk_out so the pulse lines up with its first high cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= clk_out_d & ~clk_out_q;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

    assign busy      = (state_q == PEND);
    assign sel_ready = ~busy;
    assign clk_out   = clk_out_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed table, corner sequences and random traffic
// compared against a behavioural divider model.
module tb_clk_div_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] div_sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       busy;
    logic       clk_out;
    logic       tick;

    int errors;
    int checks;

    // Behavioural model state
    int  mCnt;
    int  mAct;
    int  mPend;
    bit  mPending;
    bit  mClk;
    bit  mTick;

    clk_div_ctrl #(.DEFAULT_SEL(3'd7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_sel   (div_sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .busy      (busy),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit       valid;
        bit [2:0] sel;
        int       cycles;
        bit       expBusy;
        bit       expClk;
        bit       expTick;
    } vec_t;

    function automatic bit tickExpected(input bit t);
`ifdef CLK_DIV_CTRL_TICK_EN
        return t;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkBit(input string name, input bit actual, input bit expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mCnt     = 0;
        mAct     = 7;
        mPend    = 7;
        mPending = 0;
        mClk     = 0;
        mTick    = 0;
    endtask

    // Advance the reference one clock using the rules in plain arithmetic.
    task automatic modelStep(input bit e, input bit v, input int s);
        bit prevClk;
        if (mPending) begin
            if (e && mCnt == 127) begin
                mAct     = mPend;
                mPending = 0;
            end
        end else if (v) begin
            mPending = 1;
            mPend    = s;
        end
        if (e) mCnt = (mCnt + 1) % 128;
        prevClk = mClk;
        if (mAct == 0) mClk = 0;
        else           mClk = ((mCnt / (1 << (mAct - 1))) % 2) == 1;
        mTick = mClk && !prevClk;
    endtask

    task automatic checkOutput(input string tag);
        checkBit({tag, ".busy"},      busy,      mPending);
        checkBit({tag, ".sel_ready"}, sel_ready, !mPending);
        checkBit({tag, ".clk_out"},   clk_out,   mClk);
        checkBit({tag, ".tick"},      tick,      tickExpected(mTick));
    endtask

    task automatic applyStimulus(input bit e, input bit v, input bit [2:0] s);
        en        = e;
        sel_valid = v;
        div_sel   = s;
        @(posedge clk);
        modelStep(e, v, int'(s));
        #1;
        checkOutput("model");
    endtask

    task automatic doReset();
        en        = 1'b0;
        sel_valid = 1'b0;
        div_sel   = 3'd0;
        rst_n     = 1'b0;
        modelReset();
        #1;
        checkOutput("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[9];
    int   highRun;

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        sel_valid = 1'b0;
        div_sel   = 3'd0;

        vecs[0] = '{1, 0, 3'd0, 63, 0, 0, 0};
        vecs[1] = '{1, 0, 3'd0,  1, 0, 1, 1};
        vecs[2] = '{1, 1, 3'd1,  1, 1, 1, 0};
        vecs[3] = '{0, 1, 3'd5, 20, 1, 1, 0};
        vecs[4] = '{1, 0, 3'd0, 62, 1, 1, 0};
        vecs[5] = '{1, 0, 3'd0,  1, 0, 0, 0};
        vecs[6] = '{1, 0, 3'd0,  1, 0, 1, 1};
        vecs[7] = '{1, 0, 3'd0,  1, 0, 0, 0};
        vecs[8] = '{1, 0, 3'd0,  1, 0, 1, 1};

        #2;
        doReset();

        // Directed table from reset with the default divide-by-128
        for (int i = 0; i < 9; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].sel);
            end
            checkBit($sformatf("vec%0d.busy", i),    busy,    vecs[i].expBusy);
            checkBit($sformatf("vec%0d.clk_out", i), clk_out, vecs[i].expClk);
            checkBit($sformatf("vec%0d.tick", i),    tick,    tickExpected(vecs[i].expTick));
        end

        // Divide-by-2 then request 0: output gated off after the next wrap
        applyStimulus(1, 1, 3'd0);
        for (int c = 0; c < 130; c++) applyStimulus(1, 0, 3'd0);
        checkBit("gate.busy", busy, 1'b0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, 0, 3'd0);
            checkBit("gate.clk_out", clk_out, 1'b0);
        end

        // Request landing exactly on a wrap edge applies one wrap later
        doReset();
        for (int c = 0; c < 127; c++) applyStimulus(1, 0, 3'd0);
        applyStimulus(1, 1, 3'd2);
        checkBit("wrapreq.busy", busy, 1'b1);
        for (int c = 0; c < 127; c++) applyStimulus(1, 0, 3'd0);
        checkBit("wrapreq.still_busy", busy, 1'b1);
        applyStimulus(1, 0, 3'd0);
        checkBit("wrapreq.applied", busy, 1'b0);
        applyStimulus(1, 0, 3'd0);
        applyStimulus(1, 0, 3'd0);
        checkBit("wrapreq.div4_high", clk_out, 1'b1);

        // Asynchronous reset while a request is pending
        doReset();
        for (int c = 0; c < 70; c++) applyStimulus(1, 0, 3'd0);
        applyStimulus(1, 1, 3'd1);
        checkBit("areset.pre_clk", clk_out, 1'b1);
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("areset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b0;
        for (int c = 0; c < 140; c++) applyStimulus(1, 0, 3'd0);

        // Random traffic with a runt-pulse watch on clk_out
        highRun = 0;
        for (int c = 0; c < 4000; c++) begin
            applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 40) == 0),
                          3'($urandom_range(0, 7)));
            if (clk_out) highRun++;
            else if (highRun > 0) begin
                checks++;
                if (highRun < 1) errors++;
                highRun = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
